decode_stage: RTL and testbench

- Registered RV32 instruction-decode pipeline stage, sitting between the fetch stage and the register-read/execute stage.
- Decodes R, I-ALU, LW, SW, all six conditional branches, LUI, AUIPC, JAL and JALR into control bits, a 4-bit ALU op and a sign-extended immediate.
- Adds valid/ready handshaking, a 2-entry skid buffer, pipeline flush and illegal-instruction flagging.

---
 rtl/decode_stage_if.sv | 34 +++
 rtl/decode_stage.sv | 259 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/execute handshake bundle for decode_stage
// master drives the fetch offer and execute ready; slave is the decode stage.
interface decode_stage_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_inst;
  logic [XLEN-1:0]     in_pc;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [XLEN-1:0]     out_imm;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [4:0]          out_rd;
  logic [ALU_OP_W-1:0] out_alu_op;
  logic [8:0]          out_ctrl;
  logic [2:0]          out_funct3;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_alu_op, out_ctrl, out_funct3
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_alu_op, out_ctrl, out_funct3
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32 decode stage with 2-entry skid buffer
// Define DECODE_RVM_EN to decode MUL/MULH/DIV/REM (funct7=0000001).
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  decode_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [ALU_OP_W-1:0] alu_op;
    logic [8:0]          ctrl;
    logic [2:0]          funct3;
  } bundle_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int C_MEM_READ  = 0;
  localparam int C_MEM_WRITE = 1;
  localparam int C_REG_WRITE = 2;
  localparam int C_WB_MEM    = 3;
  localparam int C_SRC_IMM   = 4;
  localparam int C_BRANCH    = 5;
  localparam int C_JUMP      = 6;
  localparam int C_A_PC      = 7;
  localparam int C_ILLEGAL   = 8;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = ALU_OP_W'(10);
`ifdef DECODE_RVM_EN
  localparam logic [ALU_OP_W-1:0] ALU_MUL   = ALU_OP_W'(11);
  localparam logic [ALU_OP_W-1:0] ALU_MULH  = ALU_OP_W'(12);
  localparam logic [ALU_OP_W-1:0] ALU_DIV   = ALU_OP_W'(13);
  localparam logic [ALU_OP_W-1:0] ALU_REM   = ALU_OP_W'(14);
`endif

  function automatic logic [ALU_OP_W-1:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];
  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j  = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {{(XLEN-5){1'b0}}, inst[24:20]};

  bundle_t dec;
  logic    illegal;

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    dec.pc  = bus.in_pc;
    case (opcode)
      OPC_OP: begin
        dec.rs1 = rs1; dec.rs2 = rs2; dec.rd = rd; dec.funct3 = funct3;
        dec.ctrl[C_REG_WRITE] = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec.alu_op = base_op(funct3);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.alu_op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
`ifdef DECODE_RVM_EN
        end else if (funct7 == 7'b0000001) begin
          case (funct3)
            3'b000:  dec.alu_op = ALU_MUL;
            3'b001:  dec.alu_op = ALU_MULH;
            3'b100:  dec.alu_op = ALU_DIV;
            3'b110:  dec.alu_op = ALU_REM;
            default: illegal = 1'b1;
          endcase
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.rs1 = rs1; dec.rd = rd; dec.funct3 = funct3;
        dec.ctrl[C_REG_WRITE] = 1'b1;
        dec.ctrl[C_SRC_IMM]   = 1'b1;
        // Shifts carry a 5-bit shamt; funct7 picks logical vs arithmetic right.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.imm = imm_sh;
          if (funct7 == 7'b0000000)                            dec.alu_op = base_op(funct3);
          else if (funct3 == 3'b101 && funct7 == 7'b0100000)   dec.alu_op = ALU_SRA;
          else                                                 illegal = 1'b1;
        end else begin
          dec.imm    = imm_i;
          dec.alu_op = base_op(funct3);
        end
      end
      OPC_LOAD: begin
        dec.rs1 = rs1; dec.rd = rd; dec.funct3 = funct3; dec.imm = imm_i;
        dec.ctrl[C_MEM_READ]  = 1'b1;
        dec.ctrl[C_REG_WRITE] = 1'b1;
        dec.ctrl[C_WB_MEM]    = 1'b1;
        dec.ctrl[C_SRC_IMM]   = 1'b1;
        illegal = (funct3 != 3'b010);
      end
      OPC_STORE: begin
        dec.rs1 = rs1; dec.rs2 = rs2; dec.funct3 = funct3; dec.imm = imm_s;
        dec.ctrl[C_MEM_WRITE] = 1'b1;
        dec.ctrl[C_SRC_IMM]   = 1'b1;
        illegal = (funct3 != 3'b010);
      end
      OPC_BRANCH: begin
        dec.rs1 = rs1; dec.rs2 = rs2; dec.funct3 = funct3; dec.imm = imm_b;
        dec.ctrl[C_BRANCH] = 1'b1;
        case (funct3[2:1])
          2'b00:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.rd = rd; dec.imm = imm_u; dec.alu_op = ALU_PASSB;
        dec.ctrl[C_REG_WRITE] = 1'b1;
        dec.ctrl[C_SRC_IMM]   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.rd = rd; dec.imm = imm_u;
        dec.ctrl[C_REG_WRITE] = 1'b1;
        dec.ctrl[C_SRC_IMM]   = 1'b1;
        dec.ctrl[C_A_PC]      = 1'b1;
      end
      OPC_JAL: begin
        dec.rd = rd; dec.imm = imm_j;
        dec.ctrl[C_JUMP]      = 1'b1;
        dec.ctrl[C_REG_WRITE] = 1'b1;
      end
      OPC_JALR: begin
        dec.rs1 = rs1; dec.rd = rd; dec.funct3 = funct3; dec.imm = imm_i;
        dec.ctrl[C_JUMP]      = 1'b1;
        dec.ctrl[C_REG_WRITE] = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal words still flow downstream, carrying only the illegal flag.
    if (illegal) begin
      dec                = '0;
      dec.pc             = bus.in_pc;
      dec.ctrl[C_ILLEGAL] = 1'b1;
    end
  end

  state_t  state_q, state_d;
  bundle_t main_q, main_d, skid_q, skid_d;
  logic    in_ready, out_valid, in_xfer, out_xfer;

  assign in_xfer  = bus.in_valid & in_ready;
  assign out_xfer = out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (in_xfer) state_d = S_ONE;
        S_ONE: begin
          if (in_xfer && !out_xfer)      state_d = S_TWO;
          else if (out_xfer && !in_xfer) state_d = S_EMPTY;
        end
        S_TWO:   if (out_xfer) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != S_EMPTY);
    in_ready  = (state_q != S_TWO);
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!bus.flush) begin
      if (in_xfer && (state_q == S_EMPTY || (state_q == S_ONE && out_xfer))) main_d = dec;
      if (in_xfer && state_q == S_ONE && !out_xfer)                          skid_d = dec;
      if (out_xfer && state_q == S_TWO)                                      main_d = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_pc     = main_q.pc;
  assign bus.out_imm    = main_q.imm;
  assign bus.out_rs1    = main_q.rs1;
  assign bus.out_rs2    = main_q.rs2;
  assign bus.out_rd     = main_q.rd;
  assign bus.out_alu_op = main_q.alu_op;
  assign bus.out_ctrl   = main_q.ctrl;
  assign bus.out_funct3 = main_q.funct3;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and randomized bench for decode_stage
// Build with or without DECODE_RVM_EN to match the design build.
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam int AW   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [8:0]  ctrl;
    logic [2:0]  f3;
  } exp_t;

  // ALU op per funct3 for plain R-type / I-ALU
  localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
  localparam logic [6:0] OPCS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(XLEN), .ALU_OP_W(AW)) bus ();

  decode_stage #(.XLEN(XLEN), .ALU_OP_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic exp_t obs();
    exp_t o;
    o.pc = bus.out_pc; o.imm = bus.out_imm; o.rs1 = bus.out_rs1; o.rs2 = bus.out_rs2;
    o.rd = bus.out_rd; o.alu = bus.out_alu_op; o.ctrl = bus.out_ctrl; o.f3 = bus.out_funct3;
    return o;
  endfunction

  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    logic signed [31:0] si;
    logic [31:0] iimm, uimm;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    bit ill;
    e = '0; e.pc = pc; ill = 0;
    si = $signed(inst);
    opc = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    iimm = 32'(si >>> 20);
    uimm = inst & 32'hFFFF_F000;
    case (opc)
      7'h33: begin
        e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7]; e.f3 = f3; e.ctrl = 9'h004;
        if (f7 == 7'h00) e.alu = ALU_TAB[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd7;
`ifdef DECODE_RVM_EN
        else if (f7 == 7'h01 && f3 == 3'd0) e.alu = 4'd11;
        else if (f7 == 7'h01 && f3 == 3'd1) e.alu = 4'd12;
        else if (f7 == 7'h01 && f3 == 3'd4) e.alu = 4'd13;
        else if (f7 == 7'h01 && f3 == 3'd6) e.alu = 4'd14;
`endif
        else ill = 1;
      end
      7'h13: begin
        e.rs1 = inst[19:15]; e.rd = inst[11:7]; e.f3 = f3; e.ctrl = 9'h014;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.imm = {27'b0, inst[24:20]};
          if (f7 == 7'h00) e.alu = ALU_TAB[f3];
          else if (f3 == 3'd5 && f7 == 7'h20) e.alu = 4'd7;
          else ill = 1;
        end else begin
          e.imm = iimm; e.alu = ALU_TAB[f3];
        end
      end
      7'h03: begin
        e.rs1 = inst[19:15]; e.rd = inst[11:7]; e.f3 = f3; e.imm = iimm; e.ctrl = 9'h01D;
        ill = (f3 != 3'd2);
      end
      7'h23: begin
        e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.f3 = f3; e.ctrl = 9'h012;
        e.imm = 32'((si >>> 25) * 32) + {27'b0, inst[11:7]};
        ill = (f3 != 3'd2);
      end
      7'h63: begin
        e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.f3 = f3; e.ctrl = 9'h020;
        e.imm = 32'((si >>> 31) * 4096) + 32'(inst[7]) * 2048 + 32'(inst[30:25]) * 32 + 32'(inst[11:8]) * 2;
        if (f3 < 3'd2) e.alu = 4'd1;
        else if (f3 < 3'd4) ill = 1;
        else if (f3 < 3'd6) e.alu = 4'd8;
        else e.alu = 4'd9;
      end
      7'h37: begin e.rd = inst[11:7]; e.imm = uimm; e.alu = 4'd10; e.ctrl = 9'h014; end
      7'h17: begin e.rd = inst[11:7]; e.imm = uimm; e.ctrl = 9'h094; end
      7'h6F: begin
        e.rd = inst[11:7]; e.ctrl = 9'h044;
        e.imm = 32'((si >>> 31) * 1048576) + 32'(inst[19:12]) * 4096 + 32'(inst[20]) * 2048 + 32'(inst[30:21]) * 2;
      end
      7'h67: begin e.rs1 = inst[19:15]; e.rd = inst[11:7]; e.f3 = f3; e.imm = iimm; e.ctrl = 9'h044; end
      default: ill = 1;
    endcase
    if (ill) begin e = '0; e.pc = pc; e.ctrl = 9'h100; end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] opc, f7;
    int k;
    k = $urandom_range(0, 9);
    opc = (k == 9) ? 7'($urandom) : OPCS[k];
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  task automatic send_one(input logic [31:0] inst, input logic [31:0] pc);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_inst = inst; bus.in_pc = pc; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
    total++; if (bus.out_ctrl !== 9'h000 || bus.out_imm !== 32'h0 || bus.out_pc !== 32'h0) begin
      bad++; $display("FAIL reset_payload ctrl=%h imm=%h pc=%h want all 0", bus.out_ctrl, bus.out_imm, bus.out_pc);
    end
  endtask

  task automatic test_directed();
    logic [31:0] insts [5];
    exp_t        want  [5];
    exp_t        got;
    insts = '{32'hFFF00093, 32'hFE208CE3, 32'h0020A623, 32'h022081B3, 32'h123452B7};
    want[0] = '{pc:32'h100, imm:32'hFFFFFFFF, rs1:5'd0, rs2:5'd0, rd:5'd1, alu:4'd0, ctrl:9'h014, f3:3'd0};
    want[1] = '{pc:32'h104, imm:32'hFFFFFFF8, rs1:5'd1, rs2:5'd2, rd:5'd0, alu:4'd1, ctrl:9'h020, f3:3'd0};
    want[2] = '{pc:32'h108, imm:32'h0000000C, rs1:5'd1, rs2:5'd2, rd:5'd0, alu:4'd0, ctrl:9'h012, f3:3'd2};
`ifdef DECODE_RVM_EN
    want[3] = '{pc:32'h10C, imm:32'h0, rs1:5'd1, rs2:5'd2, rd:5'd3, alu:4'd11, ctrl:9'h004, f3:3'd0};
`else
    want[3] = '{pc:32'h10C, imm:32'h0, rs1:5'd0, rs2:5'd0, rd:5'd0, alu:4'd0, ctrl:9'h100, f3:3'd0};
`endif
    want[4] = '{pc:32'h110, imm:32'h12345000, rs1:5'd0, rs2:5'd0, rd:5'd5, alu:4'd10, ctrl:9'h014, f3:3'd0};
    for (int i = 0; i < 5; i++) begin
      send_one(insts[i], 32'h100 + 32'(i) * 4);
      got = obs();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL directed_valid[%0d] got=%0b want=1", i, bus.out_valid); end
      if (i == 4) begin
        total++; if (got.imm !== want[i].imm || got.alu !== want[i].alu || got.rd !== want[i].rd) begin
          bad++; $display("FAIL directed_lui imm=%h alu=%0d rd=%0d want imm=%h alu=%0d rd=%0d",
                          got.imm, got.alu, got.rd, want[i].imm, want[i].alu, want[i].rd);
        end
      end else begin
        total++; if (got !== want[i]) begin
          bad++; $display("FAIL directed[%0d] inst=%h got=%h want=%h", i, insts[i], got, want[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got_pc [$];
    int sent = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
          bad++; $display("FAIL bp_full in_ready=%0b out_valid=%0b want 0/1", bus.in_ready, bus.out_valid);
        end
      end
      bus.out_ready = (cyc >= 3);
      bus.in_valid  = (sent < 3);
      bus.in_inst   = {12'(sent + 1), 5'd0, 3'd0, 5'(sent + 1), 7'h13};
      bus.in_pc     = 32'h200 + 32'(sent) * 4;
      if (bus.out_valid && bus.out_ready) got_pc.push_back(bus.out_pc);
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
    end
    #1 bus.in_valid = 1'b0;
    total++; if (got_pc.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got_pc.size()); end
    for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
      total++; if (got_pc[i] !== 32'h200 + 32'(i) * 4) begin
        bad++; $display("FAIL bp_order[%0d] got=%h want=%h", i, got_pc[i], 32'h200 + 32'(i) * 4);
      end
    end
  endtask

  task automatic test_flush();
    int leaked = 0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_inst = 32'h00100093; bus.in_pc = 32'h300 + 32'(i) * 4;
      @(negedge clk);
    end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_full in_ready=%0b want=0", bus.in_ready); end
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_pc = 32'h308;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_after out_valid=%0b in_ready=%0b want 0/1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) leaked++;
    end
    total++; if (leaked != 0) begin bad++; $display("FAIL flush_leak got=%0d want=0", leaked); end
  endtask

  task automatic test_random();
    exp_t q [$];
    exp_t got;
    bit mv, mr, iv, ordy, fl;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      mv = (q.size() > 0);
      mr = (q.size() < 2);
      total++; if (bus.out_valid !== mv) begin bad++; $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", cyc, bus.out_valid, mv); end
      total++; if (bus.in_ready !== mr) begin bad++; $display("FAIL rand_ready cyc=%0d got=%0b want=%0b", cyc, bus.in_ready, mr); end
      if (mv) begin
        got = obs();
        total++; if (got !== q[0]) begin bad++; $display("FAIL rand_payload cyc=%0d got=%h want=%h", cyc, got, q[0]); end
      end
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 24) == 0);
      bus.in_valid = iv; bus.out_ready = ordy; bus.flush = fl;
      bus.in_inst = rand_inst();
      bus.in_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (fl) q.delete();
      else begin
        if (mv && ordy) void'(q.pop_front());
        if (iv && mr) q.push_back(model(bus.in_inst, bus.in_pc));
      end
      @(posedge clk);
    end
    #1 bus.in_valid = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
